// File: rtl/i2c_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cmd_pkg
//  Description : Shared definitions for the I2C byte-command interface and the
//                HDMI configuration sequencer: command encodings, the delay
//                entry marker, FSM/phase enumerations and a phase-to-command
//                helper.
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_cmd_pkg;

    // I2C master byte-command encodings
    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    // A table entry whose register byte is this value is a delay, not a write
    localparam logic [7:0] DELAY_MARK = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PWRUP    = 4'd1,
        ST_FETCH    = 4'd2,
        ST_ISSUE    = 4'd3,
        ST_WAITRSP  = 4'd4,
        ST_DELAY    = 4'd5,
        ST_STOP_NAK = 4'd6,
        ST_FIN      = 4'd7,
        ST_FAIL     = 4'd8
    } seq_state_t;

    // Phases of one single-register write transaction
    typedef enum logic [2:0] {
        PH_START = 3'd0,
        PH_ADDR  = 3'd1,
        PH_REG   = 3'd2,
        PH_VAL   = 3'd3,
        PH_STOP  = 3'd4
    } phase_t;

    function automatic logic [1:0] phase_cmd(input phase_t ph);
        case (ph)
            PH_START: return CMD_START;
            PH_STOP:  return CMD_STOP;
            default:  return CMD_WRITE;
        endcase
    endfunction

endpackage : i2c_cmd_pkg
`default_nettype wire

// File: rtl/hdmi_cfg_rom.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_cfg_rom
//  Description : N_ENTRIES x 16-bit synchronous configuration ROM, one-cycle
//                read latency. Entry k occupies INIT_DATA[16*k +: 16] and is
//                formatted {reg[15:8], val[7:0]}.
//  Ports       : clk   - clock
//                addr  - entry index
//                rdata - registered entry contents
//  Revision    : 1.0  initial release
// ============================================================================
module hdmi_cfg_rom #(
    parameter int                        N_ENTRIES = 16,
    parameter int                        AW        = $clog2(N_ENTRIES),
    parameter logic [N_ENTRIES*16-1:0]   INIT_DATA = {N_ENTRIES{16'hFF00}}
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [15:0]   rdata
);

    always_ff @(posedge clk) begin
        rdata <= INIT_DATA[{addr, 4'b0000} +: 16];
    end

endmodule : hdmi_cfg_rom
`default_nettype wire

// File: rtl/hdmi_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_cfg_seq
//  Description : Autonomous Sil9022 configuration sequencer. Walks the ROM
//                table and issues one I2C single-register write per entry
//                (START, W addr, W reg, W val, STOP), honouring delay entries
//                and retrying NAKed entries.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start               - pulse, begin at entry 0 (ignored if busy)
//                busy                - sequence running / bus request
//                done, err, err_idx  - sticky completion / failure status
//                i2c_cmd/data/valid  - command to the I2C master
//                i2c_ready           - master accepts on valid&ready
//                i2c_rsp, i2c_nak    - command finished / slave NAK
//  Revision    : 1.0  initial release
// ============================================================================
module hdmi_cfg_seq
    import i2c_cmd_pkg::*;
#(
    parameter logic [6:0]              DEV_ADDR  = 7'h39,
    parameter int                      N_ENTRIES = 16,
    parameter logic [N_ENTRIES*16-1:0] INIT_DATA = {N_ENTRIES{16'hFF00}},
    parameter int                      PWRUP_DLY = 20,
    parameter int                      DLY_UNIT  = 15,
    parameter int                      RETRIES   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(N_ENTRIES)-1:0] err_idx,
    output logic [1:0]                   i2c_cmd,
    output logic [7:0]                   i2c_data,
    output logic                         i2c_valid,
    input  logic                         i2c_ready,
    input  logic                         i2c_rsp,
    input  logic                         i2c_nak
);

    localparam int AW = $clog2(N_ENTRIES);
    localparam int DW = 8 + DLY_UNIT;
    localparam int RW = $clog2(RETRIES + 2);

    localparam logic [AW-1:0] LAST_IDX = AW'(N_ENTRIES - 1);
    localparam logic [RW-1:0] MAX_RTRY = RW'(RETRIES);

    seq_state_t            r_state;
    phase_t                r_phase;
    logic [AW-1:0]         r_idx;
    logic [RW-1:0]         r_retry;
    logic [PWRUP_DLY-1:0]  r_pwr_cnt;
    logic [DW-1:0]         r_dly_cnt;
    logic                  r_rd_ok;
    logic [7:0]            r_cur_reg;
    logic [7:0]            r_cur_val;

    logic [15:0]           w_rom_rdata;
    phase_t                w_next_phase;
    logic [1:0]            w_next_cmd;
    logic [7:0]            w_next_data;

    hdmi_cfg_rom #(
        .N_ENTRIES (N_ENTRIES),
        .AW        (AW),
        .INIT_DATA (INIT_DATA)
    ) u_rom (
        .clk   (clk),
        .addr  (r_idx),
        .rdata (w_rom_rdata)
    );

    always_comb begin
        w_next_phase = phase_t'(r_phase + 3'd1);
        w_next_cmd   = phase_cmd(w_next_phase);
        case (w_next_phase)
            PH_ADDR: w_next_data = {DEV_ADDR, 1'b0};
            PH_REG:  w_next_data = r_cur_reg;
            PH_VAL:  w_next_data = r_cur_val;
            default: w_next_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_phase   <= PH_START;
            r_idx     <= '0;
            r_retry   <= '0;
            r_pwr_cnt <= '0;
            r_dly_cnt <= '0;
            r_rd_ok   <= 1'b0;
            r_cur_reg <= 8'h00;
            r_cur_val <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_idx   <= '0;
            i2c_valid <= 1'b0;
            i2c_cmd   <= CMD_STOP;
            i2c_data  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        done      <= 1'b0;
                        err       <= 1'b0;
                        err_idx   <= '0;
                        r_idx     <= '0;
                        r_retry   <= '0;
                        r_pwr_cnt <= '0;
                        busy      <= 1'b1;
                        r_state   <= ST_PWRUP;
                    end
                end

                ST_PWRUP: begin
                    r_pwr_cnt <= r_pwr_cnt + 1'b1;
                    if (&r_pwr_cnt) begin
                        r_rd_ok <= 1'b0;
                        r_state <= ST_FETCH;
                    end
                end

                // First FETCH cycle only lets the ROM output catch up with r_idx
                ST_FETCH: begin
                    if (!r_rd_ok) begin
                        r_rd_ok <= 1'b1;
                    end else begin
                        r_rd_ok <= 1'b0;
                        if (w_rom_rdata[15:8] == DELAY_MARK) begin
                            if (w_rom_rdata[7:0] == 8'h00) begin
                                r_retry <= '0;
                                if (r_idx == LAST_IDX) begin
                                    r_state <= ST_FIN;
                                end else begin
                                    r_idx   <= r_idx + 1'b1;
                                    r_state <= ST_FETCH;
                                end
                            end else begin
                                r_dly_cnt <= {w_rom_rdata[7:0], {DLY_UNIT{1'b0}}};
                                r_state   <= ST_DELAY;
                            end
                        end else begin
                            r_cur_reg <= w_rom_rdata[15:8];
                            r_cur_val <= w_rom_rdata[7:0];
                            r_phase   <= PH_START;
                            i2c_cmd   <= CMD_START;
                            i2c_data  <= 8'h00;
                            i2c_valid <= 1'b1;
                            r_state   <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (i2c_ready) begin
                        i2c_valid <= 1'b0;
                        r_state   <= ST_WAITRSP;
                    end
                end

                ST_WAITRSP: begin
                    if (i2c_rsp) begin
                        if ((i2c_cmd == CMD_WRITE) && i2c_nak) begin
                            // Abandon the remaining bytes and release the bus
                            i2c_cmd   <= CMD_STOP;
                            i2c_data  <= 8'h00;
                            i2c_valid <= 1'b1;
                            r_state   <= ST_STOP_NAK;
                        end else if (r_phase == PH_STOP) begin
                            r_retry <= '0;
                            if (r_idx == LAST_IDX) begin
                                r_state <= ST_FIN;
                            end else begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= ST_FETCH;
                            end
                        end else begin
                            r_phase   <= w_next_phase;
                            i2c_cmd   <= w_next_cmd;
                            i2c_data  <= w_next_data;
                            i2c_valid <= 1'b1;
                            r_state   <= ST_ISSUE;
                        end
                    end
                end

                ST_DELAY: begin
                    r_dly_cnt <= r_dly_cnt - 1'b1;
                    if (r_dly_cnt == DW'(1)) begin
                        r_retry <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end

                // valid high: STOP not yet accepted; valid low: awaiting its rsp
                ST_STOP_NAK: begin
                    if (i2c_valid) begin
                        if (i2c_ready) begin
                            i2c_valid <= 1'b0;
                        end
                    end else if (i2c_rsp) begin
                        if (r_retry < MAX_RTRY) begin
                            r_retry   <= r_retry + 1'b1;
                            r_phase   <= PH_START;
                            i2c_cmd   <= CMD_START;
                            i2c_data  <= 8'h00;
                            i2c_valid <= 1'b1;
                            r_state   <= ST_ISSUE;
                        end else begin
                            err     <= 1'b1;
                            err_idx <= r_idx;
                            r_state <= ST_FAIL;
                        end
                    end
                end

                ST_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                ST_FAIL: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : hdmi_cfg_seq
`default_nettype wire

// File: tb/tb_hdmi_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdmi_cfg_seq
//  Description : Self-checking bench for hdmi_cfg_seq. An I2C master/slave
//                model accepts commands, answers 3 cycles later and injects
//                NAKs by transaction/byte position; a scoreboard queue holds
//                the expected command stream.
//                Table: {C7 00},{1A 10},{FF 02},{08 35}; DLY_UNIT=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hdmi_cfg_seq;
    import i2c_cmd_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_idx;
    logic [1:0] i2c_cmd;
    logic [7:0] i2c_data;
    logic       i2c_valid;
    logic       i2c_ready;
    logic       i2c_rsp;
    logic       i2c_nak;

    always #5 clk = ~clk;

    hdmi_cfg_seq #(
        .DEV_ADDR  (7'h39),
        .N_ENTRIES (4),
        .INIT_DATA (64'h0835_FF02_1A10_C700),
        .PWRUP_DLY (4),
        .DLY_UNIT  (4),
        .RETRIES   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_idx   (err_idx),
        .i2c_cmd   (i2c_cmd),
        .i2c_data  (i2c_data),
        .i2c_valid (i2c_valid),
        .i2c_ready (i2c_ready),
        .i2c_rsp   (i2c_rsp),
        .i2c_nak   (i2c_nak)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected {cmd, data}
    logic [9:0] exp_q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave/master model state
    int   pend     = 0;
    int   txn      = -1;
    int   wpos     = 0;
    int   nak_pos  = -1;
    int   nak_lo   = 0;
    int   nak_hi   = -1;
    logic nak_pend = 1'b0;
    int   acc_cnt  = 0;
    int   rsp_n    = 0;
    int   rise_n   = 0;
    int   rsp_cyc[64];
    int   rise_cyc[64];
    logic prev_valid = 1'b0;

    initial begin : responder
        logic [9:0] e;
        i2c_rsp = 1'b0;
        i2c_nak = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend       = 0;
                i2c_rsp    = 1'b0;
                i2c_nak    = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (i2c_valid && !prev_valid && rise_n < 64) begin
                    rise_cyc[rise_n] = cyc;
                    rise_n++;
                end
                prev_valid = i2c_valid;
                // nak noise outside rsp must be ignored by the DUT
                i2c_rsp = 1'b0;
                i2c_nak = ($urandom_range(0, 1) == 1);
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        i2c_rsp = 1'b1;
                        i2c_nak = nak_pend;
                        if (rsp_n < 64) begin
                            rsp_cyc[rsp_n] = cyc;
                            rsp_n++;
                        end
                    end
                end
                if (i2c_valid && i2c_ready) begin
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        check_eq("sb_unexpected_cmd", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("sb_cmd", i2c_cmd, e[9:8]);
                        if (e[9:8] == CMD_WRITE) check_eq("sb_data", i2c_data, e[7:0]);
                    end
                    if (i2c_cmd == CMD_START) begin
                        txn++;
                        wpos = 0;
                    end
                    if (i2c_cmd == CMD_WRITE) begin
                        nak_pend = (txn >= nak_lo) && (txn <= nak_hi) && (wpos == nak_pos);
                        wpos++;
                    end else begin
                        // NAK on START/STOP rsp is not qualified
                        nak_pend = ($urandom_range(0, 1) == 1);
                    end
                    pend = 3;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_cmd(input logic [1:0] c, input logic [7:0] d);
        exp_q.push_back({c, d});
    endtask

    task automatic push_entry(input logic [7:0] r, input logic [7:0] v);
        push_cmd(CMD_START, 8'h00);
        push_cmd(CMD_WRITE, 8'h72);
        push_cmd(CMD_WRITE, r);
        push_cmd(CMD_WRITE, v);
        push_cmd(CMD_STOP, 8'h00);
    endtask

    task automatic push_full();
        push_entry(8'hC7, 8'h00);
        push_entry(8'h1A, 8'h10);
        push_entry(8'h08, 8'h35);
    endtask

    task automatic clear_stats();
        rise_n  = 0;
        rsp_n   = 0;
        txn     = -1;
        acc_cnt = 0;
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({tag, "_busy_up"}, busy, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && busy; i++) tick();
        check_eq({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [1:0] c_hold;
        logic [7:0] d_hold;
        logic       stable;
        rst       = 1'b1;
        start     = 1'b0;
        i2c_ready = 1'b1;
        tick(3);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_err_idx", err_idx, 2'd0);
        check_eq("rst_valid", i2c_valid, 1'b0);
        check_eq("rst_cmd", i2c_cmd, CMD_STOP);
        check_eq("rst_data", i2c_data, 8'h00);
        rst = 1'b0;
        tick();

        // Normal run including the delay entry
        clear_stats();
        push_full();
        pulse_start("t1");
        wait_idle("t1");
        check_eq("t1_done", done, 1'b1);
        check_eq("t1_err", err, 1'b0);
        check_eq("t1_sb_empty", exp_q.size(), 0);
        check_eq("t1_cmd_count", rise_n, 15);
        check_eq("t1_delay_gap_ge32", (rise_cyc[10] - rsp_cyc[9]) >= 32, 1'b1);
        check_eq("t1_plain_gap_lt32", (rise_cyc[5] - rsp_cyc[4]) < 32, 1'b1);

        // Ready stall on a WRITE plus a start pulse while busy
        clear_stats();
        push_full();
        pulse_start("t2");
        for (int i = 0; i < 300 && !(i2c_valid && i2c_cmd == CMD_WRITE); i++) tick();
        check_eq("t2_write_reached", i2c_valid && (i2c_cmd == CMD_WRITE), 1'b1);
        i2c_ready = 1'b0;
        c_hold = i2c_cmd;
        d_hold = i2c_data;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            start = (i == 10);
            tick();
            if (i2c_valid !== 1'b1 || i2c_cmd !== c_hold || i2c_data !== d_hold) stable = 1'b0;
        end
        start = 1'b0;
        check_eq("t2_stall_stable", stable, 1'b1);
        i2c_ready = 1'b1;
        wait_idle("t2");
        check_eq("t2_done", done, 1'b1);
        check_eq("t2_sb_empty", exp_q.size(), 0);

        // NAK on the address byte of the first two attempts
        clear_stats();
        nak_pos = 0;
        nak_lo  = 0;
        nak_hi  = 1;
        repeat (2) begin
            push_cmd(CMD_START, 8'h00);
            push_cmd(CMD_WRITE, 8'h72);
            push_cmd(CMD_STOP, 8'h00);
        end
        push_full();
        pulse_start("t3");
        wait_idle("t3");
        check_eq("t3_done", done, 1'b1);
        check_eq("t3_err", err, 1'b0);
        check_eq("t3_sb_empty", exp_q.size(), 0);

        // Persistent NAK on the register byte of entry 1
        clear_stats();
        nak_pos = 1;
        nak_lo  = 1;
        nak_hi  = 1000;
        push_entry(8'hC7, 8'h00);
        repeat (4) begin
            push_cmd(CMD_START, 8'h00);
            push_cmd(CMD_WRITE, 8'h72);
            push_cmd(CMD_WRITE, 8'h1A);
            push_cmd(CMD_STOP, 8'h00);
        end
        pulse_start("t4");
        wait_idle("t4");
        check_eq("t4_err", err, 1'b1);
        check_eq("t4_err_idx", err_idx, 2'd1);
        check_eq("t4_done", done, 1'b0);
        check_eq("t4_sb_empty", exp_q.size(), 0);
        tick(10);
        check_eq("t4_no_more_cmds", acc_cnt, 21);
        check_eq("t4_err_held", err, 1'b1);

        // Reset while waiting for a response, then replay from entry 0
        clear_stats();
        nak_hi = -1;
        push_full();
        pulse_start("t5");
        for (int i = 0; i < 300 && !(acc_cnt >= 2 && !i2c_valid); i++) tick();
        check_eq("t5_waitrsp_reached", (acc_cnt >= 2) && !i2c_valid, 1'b1);
        rst = 1'b1;
        tick();
        check_eq("t5_rst_valid", i2c_valid, 1'b0);
        check_eq("t5_rst_busy", busy, 1'b0);
        check_eq("t5_rst_done", done, 1'b0);
        check_eq("t5_rst_err", err, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        tick(2);
        clear_stats();
        push_full();
        pulse_start("t5b");
        wait_idle("t5b");
        check_eq("t5_done", done, 1'b1);
        check_eq("t5_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hdmi_cfg_seq
`default_nettype wire
